// File: rtl/activation_lut_loader.sv
// Write side of the activation-function LUT: serial valid/ready loader into a
// DEPTH-entry register file, with a combinational (base, next_data) read port.
module activation_lut_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [ADDR_W:0]   o_load_count,
    output logic              o_load_done,
    output logic              o_table_valid,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] o_base,
    output logic [DATA_W-1:0] o_next_data
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t                        r_state, w_state_nxt;
    logic [ADDR_W-1:0]             r_wr_ptr;
    logic [ADDR_W:0]               r_load_count;
    logic                          r_load_done;
    logic                          r_table_valid;
    logic [DEPTH-1:0][DATA_W-1:0]  r_mem;
    logic                          w_xfer;
    logic                          w_last;
    logic [ADDR_W-1:0]             w_next_addr;

    // A restart in the same cycle as a transfer discards the transfer.
    assign w_xfer = i_wr_valid & o_wr_ready & ~i_load_start;
    assign w_last = w_xfer & (r_wr_ptr == ADDR_W'(DEPTH-1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_load_start) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_last)       w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_wr_ready = (r_state == S_LOAD);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr      <= '0;
            r_load_count  <= '0;
            r_load_done   <= 1'b0;
            r_table_valid <= 1'b0;
            r_mem         <= '0;
        end else begin
            r_load_done <= w_last;
            if (i_load_start) begin
                r_wr_ptr      <= '0;
                r_load_count  <= '0;
                r_table_valid <= 1'b0;
            end else if (w_xfer) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
                r_load_count    <= r_load_count + (ADDR_W+1)'(1);
                if (w_last) r_table_valid <= 1'b1;
            end
        end
    end

    // Top entry saturates rather than wrapping to entry 0.
    assign w_next_addr = (i_address == ADDR_W'(DEPTH-1)) ? i_address : i_address + ADDR_W'(1);

    assign o_base        = r_mem[i_address];
    assign o_next_data   = r_mem[w_next_addr];
    assign o_load_count  = r_load_count;
    assign o_load_done   = r_load_done;
    assign o_table_valid = r_table_valid;

endmodule

// File: tb/tb_activation_lut_loader.sv
// Directed bench for activation_lut_loader: loads, gaps, restarts, resets,
// and the saturating read port.
`timescale 1ns/100ps
module tb_activation_lut_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic [4:0] load_count;
    logic       load_done;
    logic       table_valid;
    logic [3:0] address = 4'd0;
    logic [7:0] base;
    logic [7:0] next_data;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    logic [7:0] vals [16];
    logic [7:0] mdl  [16];

    activation_lut_loader #(.DATA_W(8), .ADDR_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_load_start(load_start),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
        .o_load_count(load_count), .o_load_done(load_done),
        .o_table_valid(table_valid), .i_address(address),
        .o_base(base), .o_next_data(next_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sweeps every address against the bench model; returns aligned to a negedge.
    task automatic check_table(input string tag);
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #0.2;
            chk({tag, "_base"}, $signed(base), $signed(mdl[a]));
            chk({tag, "_next"}, $signed(next_data), $signed(mdl[(a == 15) ? 15 : a + 1]));
        end
        @(negedge clk);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("start_count", load_count, 0);
        chk("start_ready", wr_ready, 1);
        chk("start_tvalid", table_valid, 0);
    endtask

    // Streams vals[0..n-1]; optional random idle cycles carry garbage data.
    task automatic stream(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                wr_valid = 1'b0;
                wr_data  = 8'hA5;
                @(negedge clk);
                chk("gap_count", load_count, k);
            end
            chk("xfer_ready", wr_ready, 1);
            wr_valid = 1'b1;
            wr_data  = vals[k];
            @(negedge clk);
            mdl[k] = vals[k];
            chk("xfer_count", load_count, k + 1);
            if (k + 1 < 16) chk("load_tvalid", table_valid, 0);
        end
        wr_valid = 1'b0;
    endtask

    // Called at the negedge right after the 16th transfer edge.
    task automatic finish_check();
        chk("done_pulse", load_done, 1);
        chk("done_tvalid", table_valid, 1);
        chk("done_count", load_count, 16);
        chk("done_ready", wr_ready, 0);
        @(negedge clk);
        chk("done_low", load_done, 0);
        chk("done_hold", load_count, 16);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;

        // T1: async reset asserted mid-cycle
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_ready", wr_ready, 0);
        chk("rst_count", load_count, 0);
        chk("rst_done", load_done, 0);
        chk("rst_tvalid", table_valid, 0);
        @(negedge clk);
        check_table("rst");
        rst = 1'b0;
        @(negedge clk);

        // T2: full load of -8*i, back-to-back
        for (int i = 0; i < 16; i++) vals[i] = 8'(-8 * i);
        d0 = done_cnt;
        start_load();
        stream(16, 0);
        finish_check();
        chk("t2_done_cnt", done_cnt - d0, 1);
        address = 4'd3; #0.2;
        chk("t2_base3", $signed(base), -24);
        chk("t2_next3", $signed(next_data), -32);

        // T3: read-port boundaries
        address = 4'd15; #0.2;
        chk("t3_base15", $signed(base), -120);
        chk("t3_next15", $signed(next_data), -120);
        address = 4'd0; #0.2;
        chk("t3_base0", $signed(base), 0);
        chk("t3_next0", $signed(next_data), -8);
        @(negedge clk);
        check_table("t2");

        // T4: gapped load, then wr_valid in IDLE must do nothing
        for (int i = 0; i < 16; i++) vals[i] = 8'(9 * i - 60);
        start_load();
        stream(16, 1);
        finish_check();
        wr_valid = 1'b1;
        wr_data  = 8'h7F;
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        chk("idle_count", load_count, 16);
        chk("idle_ready", wr_ready, 0);
        chk("idle_tvalid", table_valid, 1);
        check_table("t4");

        // T5: restart after 5 transfers; restart cycle's transfer discarded
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) vals[i] = 8'h22;
        start_load();
        stream(5, 0);
        load_start = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 8'h33;
        @(negedge clk);
        load_start = 1'b0;
        wr_valid   = 1'b0;
        chk("rs_count", load_count, 0);
        chk("rs_ready", wr_ready, 1);
        chk("rs_tvalid", table_valid, 0);
        for (int i = 0; i < 16; i++) vals[i] = 8'h11;
        stream(16, 0);
        finish_check();
        chk("t5_done_cnt", done_cnt - d0, 1);
        check_table("t5");

        // Restart coinciding with the final transfer: restart wins
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) vals[i] = 8'h44;
        start_load();
        stream(15, 0);
        load_start = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 8'h55;
        @(negedge clk);
        load_start = 1'b0;
        wr_valid   = 1'b0;
        chk("col_done", load_done, 0);
        chk("col_count", load_count, 0);
        chk("col_ready", wr_ready, 1);
        chk("col_tvalid", table_valid, 0);
        @(negedge clk);
        chk("col_done_cnt", done_cnt - d0, 0);
        check_table("col");

        // T6: reset after 7 transfers, then a clean full load
        for (int i = 0; i < 16; i++) vals[i] = 8'h66;
        start_load();
        stream(7, 0);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        chk("t6_tvalid", table_valid, 0);
        chk("t6_ready", wr_ready, 0);
        chk("t6_count", load_count, 0);
        @(negedge clk);
        check_table("t6_rst");
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) vals[i] = 8'(7 * i - 50);
        d0 = done_cnt;
        start_load();
        stream(16, 1);
        finish_check();
        chk("t6_done_cnt", done_cnt - d0, 1);
        check_table("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
